// File: rtl/temporizador_regressivo_if.sv
// Board-facing signal bundle for the countdown timer: switches, pushbuttons, LEDs
// and the four 7-segment digits.
// Ports: SW[9:0] and KEY[3:0] (active-low) go into the timer; LEDR[9:0] and HEX0..HEX3 come out.
// Modports: master = board/stimulus side, slave = timer side.
interface temporizador_regressivo_if;
  logic [9:0] SW;
  logic [3:0] KEY;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;

  modport master (
    output SW,
    output KEY,
    input  LEDR,
    input  HEX0,
    input  HEX1,
    input  HEX2,
    input  HEX3
  );

  modport slave (
    input  SW,
    input  KEY,
    output LEDR,
    output HEX0,
    output HEX1,
    output HEX2,
    output HEX3
  );
endinterface

// File: rtl/temporizador_regressivo.sv
// MM:SS countdown timer with start/pause, reload, and separate minute/second loads from SW[5:0].
// Ports: CLOCK_50, reset (synchronous, active-high), bus (slave modport: SW, KEY in; LEDR, HEX0..HEX3 out).
// Latency: key action 3 edges after the pin falls; HEX/LEDR registered one edge after the state/time registers.
// Build option: define ALARM_BLINK_EN to make LEDR[9:2] blink while expired; otherwise they stay lit.
module temporizador_regressivo #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 12500000
) (
  input logic                      CLOCK_50,
  input logic                      reset,
  temporizador_regressivo_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [5:0]      MAX_VAL   = 6'd59;

  // 0..9 to active-low segments {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Key synchronizer plus a third stage that remembers the previous synchronized level
  logic [3:0]    r_key_s1;
  logic [3:0]    r_key_s2;
  logic [3:0]    r_key_s3;

  state_t        r_state;
  logic [5:0]    r_pmin;
  logic [5:0]    r_psec;
  logic [5:0]    r_min;
  logic [5:0]    r_sec;
  logic [PW-1:0] r_presc;

  logic [6:0]    r_hex0;
  logic [6:0]    r_hex1;
  logic [6:0]    r_hex2;
  logic [6:0]    r_hex3;
  logic [9:0]    r_ledr;

  state_t        w_state_nxt;
  logic [5:0]    w_pmin_nxt;
  logic [5:0]    w_psec_nxt;
  logic [5:0]    w_min_nxt;
  logic [5:0]    w_sec_nxt;
  logic [PW-1:0] w_presc_nxt;

  logic [3:0]    w_press;
  logic          w_do_reload;
  logic          w_do_lmin;
  logic          w_do_lsec;
  logic          w_do_start;
  logic [5:0]    w_sw_val;
  logic          w_unused_sw;
  logic          w_tick;
  logic [5:0]    w_dec_min;
  logic [5:0]    w_dec_sec;
  logic          w_dec_zero;
  logic [7:0]    w_alarm;

  // Buttons idle high, so a press is the synchronized level going 1 -> 0
  assign w_press = r_key_s3 & ~r_key_s2;

  // Only the highest-priority press survives: KEY1 > KEY2 > KEY3 > KEY0
  assign w_do_reload = w_press[1];
  assign w_do_lmin   = ~w_press[1] & w_press[2];
  assign w_do_lsec   = ~w_press[1] & ~w_press[2] & w_press[3];
  assign w_do_start  = ~(|w_press[3:1]) & w_press[0];

  assign w_sw_val    = (bus.SW[5:0] > MAX_VAL) ? MAX_VAL : bus.SW[5:0];
  assign w_unused_sw = ^bus.SW[9:6];

  assign w_tick = (r_state == S_RUNNING) && (r_presc == PRESC_MAX);

  // One-second decrement with borrow from minutes
  always_comb begin
    w_dec_min = r_min;
    w_dec_sec = r_sec;
    if (r_sec != 6'd0) begin
      w_dec_sec = r_sec - 6'd1;
    end else if (r_min != 6'd0) begin
      w_dec_min = r_min - 6'd1;
      w_dec_sec = MAX_VAL;
    end
  end

  assign w_dec_zero = (w_dec_min == 6'd0) && (w_dec_sec == 6'd0);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_key_s1 <= 4'hF;
      r_key_s2 <= 4'hF;
      r_key_s3 <= 4'hF;
      r_state  <= S_IDLE;
      r_pmin   <= 6'd0;
      r_psec   <= 6'd0;
      r_min    <= 6'd0;
      r_sec    <= 6'd0;
      r_presc  <= '0;
    end else begin
      r_key_s1 <= bus.KEY;
      r_key_s2 <= r_key_s1;
      r_key_s3 <= r_key_s2;
      r_state  <= w_state_nxt;
      r_pmin   <= w_pmin_nxt;
      r_psec   <= w_psec_nxt;
      r_min    <= w_min_nxt;
      r_sec    <= w_sec_nxt;
      r_presc  <= w_presc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pmin_nxt  = r_pmin;
    w_psec_nxt  = r_psec;
    w_min_nxt   = r_min;
    w_sec_nxt   = r_sec;
    w_presc_nxt = '0;

    // Prescaler advances only while running and freezes while paused
    case (r_state)
      S_RUNNING: w_presc_nxt = (r_presc == PRESC_MAX) ? '0 : r_presc + PW'(1);
      S_PAUSED:  w_presc_nxt = r_presc;
      default:   w_presc_nxt = '0;
    endcase

    if (w_do_reload) begin
      w_min_nxt   = r_pmin;
      w_sec_nxt   = r_psec;
      w_state_nxt = S_IDLE;
      w_presc_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE, S_EXPIRED: begin
          if (w_do_lmin) begin
            w_pmin_nxt  = w_sw_val;
            w_min_nxt   = w_sw_val;
            w_state_nxt = S_IDLE;
          end else if (w_do_lsec) begin
            w_psec_nxt  = w_sw_val;
            w_sec_nxt   = w_sw_val;
            w_state_nxt = S_IDLE;
          end else if (w_do_start && (r_state == S_IDLE) &&
                       ((r_min != 6'd0) || (r_sec != 6'd0))) begin
            w_state_nxt = S_RUNNING;
          end
        end
        S_RUNNING: begin
          if (w_do_start) begin
            w_state_nxt = S_PAUSED;
          end
          // A tick in the same cycle still decrements; reaching zero overrides a pause
          if (w_tick) begin
            w_min_nxt = w_dec_min;
            w_sec_nxt = w_dec_sec;
            if (w_dec_zero) begin
              w_state_nxt = S_EXPIRED;
            end
          end
        end
        S_PAUSED: begin
          if (w_do_start) begin
            w_state_nxt = S_RUNNING;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

`ifdef ALARM_BLINK_EN
  localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_on;

  // Phase restarts lit on every entry to EXPIRED
  always_ff @(posedge CLOCK_50) begin
    if (reset || (r_state != S_EXPIRED)) begin
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else if (r_blink_cnt == BLINK_MAX) begin
      r_blink_cnt <= '0;
      r_blink_on  <= ~r_blink_on;
    end else begin
      r_blink_cnt <= r_blink_cnt + BW'(1);
    end
  end

  assign w_alarm = (r_state == S_EXPIRED) ? {8{r_blink_on}} : 8'h00;
`else
  assign w_alarm = (r_state == S_EXPIRED) ? 8'hFF : 8'h00;
`endif

  // Display and LEDs follow the registered time/state by one edge
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_hex0 <= 7'b1000000;
      r_hex1 <= 7'b1000000;
      r_hex2 <= 7'b1000000;
      r_hex3 <= 7'b1000000;
      r_ledr <= 10'h000;
    end else begin
      r_hex3 <= seg7(4'(r_min / 6'd10));
      r_hex2 <= seg7(4'(r_min % 6'd10));
      r_hex1 <= seg7(4'(r_sec / 6'd10));
      r_hex0 <= seg7(4'(r_sec % 6'd10));
      r_ledr <= {w_alarm, (r_state == S_PAUSED), (r_state == S_RUNNING)};
    end
  end

  assign bus.HEX0 = r_hex0;
  assign bus.HEX1 = r_hex1;
  assign bus.HEX2 = r_hex2;
  assign bus.HEX3 = r_hex3;
  assign bus.LEDR = r_ledr;

endmodule

// File: tb/tb_temporizador_regressivo.sv
// Self-checking bench for temporizador_regressivo with TICK_DIV=10, BLINK_DIV=4.
// Ports: drives the board interface (SW, KEY) and reset; observes HEX0..HEX3 and LEDR.
// Expected displays are queued when stimulus is applied and popped when the display is sampled.
module tb_temporizador_regressivo;
  localparam int TICK_DIV  = 10;
  localparam int BLINK_DIV = 4;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;

  temporizador_regressivo_if bus();

  temporizador_regressivo #(
    .TICK_DIV (TICK_DIV),
    .BLINK_DIV(BLINK_DIV)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [27:0] exp_q[$];

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [27:0] disp(input int m, input int s);
    return {seg(m / 10), seg(m % 10), seg(s / 10), seg(s % 10)};
  endfunction

  function automatic logic [27:0] cur_disp();
    return {bus.HEX3, bus.HEX2, bus.HEX1, bus.HEX0};
  endfunction

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Pin low now; the timer acts on the 3rd edge; returns just after that edge
  task automatic press_mask(input logic [3:0] m);
    bus.KEY = ~m;
    step();
    step();
    bus.KEY = 4'hF;
    step();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.KEY = 4'hF;
    step();
    step();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic wait_change(input int budget, output int n);
    logic [27:0] prev;
    prev = cur_disp();
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (cur_disp() !== prev) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.SW  = 10'h000;
    bus.KEY = 4'hF;
    reset   = 1'b1;
    step();
    step();
    n_checks++;
    if (cur_disp() !== disp(0, 0)) begin
      n_errors++;
      $display("FAIL reset_hex got=%h exp=%h", cur_disp(), disp(0, 0));
    end
    n_checks++;
    if (bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL reset_ledr got=%h exp=000", bus.LEDR);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_start_zero();
    press_mask(4'b0001);
    step();
    step();
    n_checks++;
    if (bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL start_zero_ledr got=%h exp=000", bus.LEDR);
    end
  endtask

  task automatic test_load_clamp();
    logic [27:0] got, exp;
    bus.SW = 10'd63;
    press_mask(4'b0100);
    exp_q.push_back(disp(59, 0));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL clamp_min got=%h exp=%h", got, exp);
    end
    press_mask(4'b1000);
    exp_q.push_back(disp(59, 59));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL clamp_sec got=%h exp=%h", got, exp);
    end
    // Upper switch bits must not affect the loaded value
    bus.SW = 10'h3C7;
    press_mask(4'b0100);
    exp_q.push_back(disp(7, 59));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL load_sw_upper got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_countdown();
    logic [27:0] got, exp;
    logic [7:0]  exp_alarm;
    int          n;
    do_reset();
    bus.SW = 10'd2;
    press_mask(4'b1000);
    exp_q.push_back(disp(0, 2));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL cd_load got=%h exp=%h", got, exp);
    end
    press_mask(4'b0001);
    exp_q.push_back(disp(0, 1));
    exp_q.push_back(disp(0, 0));
    step();
    n_checks++;
    if (bus.LEDR !== 10'h001) begin
      n_errors++;
      $display("FAIL cd_running_led got=%h exp=001", bus.LEDR);
    end
    for (int k = 0; k < 2; k++) begin
      wait_change(25, n);
      got = cur_disp();
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_checks++;
      if (got !== exp || n != 10) begin
        n_errors++;
        $display("FAIL cd_tick%0d got=%h after %0d exp=%h after 10", k, got, n, exp);
      end
    end
    // Now one edge after entering EXPIRED
    n_checks++;
    if (bus.LEDR[1:0] !== 2'b00) begin
      n_errors++;
      $display("FAIL cd_expired_led got=%b exp=00", bus.LEDR[1:0]);
    end
    for (int i = 1; i <= 12; i++) begin
`ifdef ALARM_BLINK_EN
      exp_alarm = (((i - 1) / BLINK_DIV) % 2 == 0) ? 8'hFF : 8'h00;
`else
      exp_alarm = 8'hFF;
`endif
      n_checks++;
      if (bus.LEDR[9:2] !== exp_alarm) begin
        n_errors++;
        $display("FAIL alarm_c%0d got=%h exp=%h", i, bus.LEDR[9:2], exp_alarm);
      end
      step();
    end
    press_mask(4'b0001);
    step();
    n_checks++;
    if (bus.LEDR[1:0] !== 2'b00) begin
      n_errors++;
      $display("FAIL expired_start_ignored got=%b exp=00", bus.LEDR[1:0]);
    end
    press_mask(4'b0010);
    exp_q.push_back(disp(0, 2));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL expired_reload got=%h led=%h exp=%h led=000", got, bus.LEDR, exp);
    end
  endtask

  task automatic test_minute_borrow();
    logic [27:0] got, exp;
    int          n;
    do_reset();
    bus.SW = 10'd1;
    press_mask(4'b0100);
    exp_q.push_back(disp(1, 0));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL borrow_load got=%h exp=%h", got, exp);
    end
    press_mask(4'b0001);
    exp_q.push_back(disp(0, 59));
    exp_q.push_back(disp(0, 58));
    wait_change(30, n);
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || n != 11) begin
      n_errors++;
      $display("FAIL borrow_first got=%h after %0d exp=%h after 11", got, n, exp);
    end
    wait_change(30, n);
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || n != 10) begin
      n_errors++;
      $display("FAIL borrow_second got=%h after %0d exp=%h after 10", got, n, exp);
    end
  endtask

  task automatic test_pause();
    logic [27:0] got, exp, held;
    int          n, changes;
    do_reset();
    bus.SW = 10'd5;
    press_mask(4'b1000);
    press_mask(4'b0001);
    exp_q.push_back(disp(0, 4));
    repeat (9) step();
    // Pause lands 12 running edges after start
    press_mask(4'b0001);
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL pause_first_tick got=%h exp=%h", got, exp);
    end
    step();
    n_checks++;
    if (bus.LEDR !== 10'h002) begin
      n_errors++;
      $display("FAIL pause_led got=%h exp=002", bus.LEDR);
    end
    held = cur_disp();
    changes = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (cur_disp() !== held) changes++;
    end
    n_checks++;
    if (changes != 0 || bus.LEDR !== 10'h002) begin
      n_errors++;
      $display("FAIL pause_hold changes=%0d led=%h exp changes=0 led=002", changes, bus.LEDR);
    end
    press_mask(4'b0001);
    exp_q.push_back(disp(0, 3));
    wait_change(30, n);
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || n != 9 || bus.LEDR !== 10'h001) begin
      n_errors++;
      $display("FAIL resume_tick got=%h after %0d led=%h exp=%h after 9 led=001", got, n, bus.LEDR, exp);
    end
  endtask

  task automatic test_reload_running();
    logic [27:0] got, exp;
    int          n;
    do_reset();
    bus.SW = 10'd3;
    press_mask(4'b1000);
    press_mask(4'b0001);
    exp_q.push_back(disp(0, 2));
    wait_change(30, n);
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || n != 11) begin
      n_errors++;
      $display("FAIL reload_pre got=%h after %0d exp=%h after 11", got, n, exp);
    end
    press_mask(4'b0010);
    exp_q.push_back(disp(0, 3));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL reload_running got=%h led=%h exp=%h led=000", got, bus.LEDR, exp);
    end
    press_mask(4'b0001);
    repeat (5) step();
    reset = 1'b1;
    step();
    n_checks++;
    if (cur_disp() !== disp(0, 0) || bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL reset_midrun got=%h led=%h exp=%h led=000", cur_disp(), bus.LEDR, disp(0, 0));
    end
    reset = 1'b0;
    repeat (25) step();
    n_checks++;
    if (cur_disp() !== disp(0, 0) || bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL after_reset_idle got=%h led=%h exp=%h led=000", cur_disp(), bus.LEDR, disp(0, 0));
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] got, exp;
    int          changes;
    do_reset();
    bus.SW = 10'd4;
    // KEY2 outranks KEY3: only minutes load
    press_mask(4'b1100);
    exp_q.push_back(disp(4, 0));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL prio_k2_k3 got=%h exp=%h", got, exp);
    end
    // KEY1 outranks KEY0: start is dropped
    press_mask(4'b0011);
    step();
    step();
    n_checks++;
    if (bus.LEDR !== 10'h000) begin
      n_errors++;
      $display("FAIL prio_k1_k0 led=%h exp=000", bus.LEDR);
    end
    // Pause lands on the tick edge: decrement still applies
    press_mask(4'b0001);
    repeat (7) step();
    press_mask(4'b0001);
    exp_q.push_back(disp(3, 59));
    step();
    got = cur_disp();
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_checks++;
    if (got !== exp || bus.LEDR !== 10'h002) begin
      n_errors++;
      $display("FAIL tick_and_pause got=%h led=%h exp=%h led=002", got, bus.LEDR, exp);
    end
    changes = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (cur_disp() !== got) changes++;
    end
    n_checks++;
    if (changes != 0) begin
      n_errors++;
      $display("FAIL tick_and_pause_hold changes=%0d exp=0", changes);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.SW  = 10'h000;
    bus.KEY = 4'hF;
    test_reset();
    test_start_zero();
    test_load_clamp();
    test_countdown();
    test_minute_borrow();
    test_pause();
    test_reload_running();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/temporizador_regressivo.md
TEMPORIZADOR_REGRESSIVO -- requirements
Module: temporizador_regressivo

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, CLOCK_50 cycles per 1 s countdown tick.
REQ-002 SHALL have parameter BLINK_DIV, default 12500000, CLOCK_50 cycles per alarm blink half-period.
REQ-003 SHALL have port CLOCK_50  input  1  system clock, 50 MHz; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port SW  input  10  SW[5:0] preset value; SW[9:6] unused.
REQ-006 SHALL have port KEY  input  4  active-low pushbuttons: KEY[0] start/pause, KEY[1] reload, KEY[2] load minutes, KEY[3] load seconds.
REQ-007 SHALL have port LEDR  output  10  LEDR[0] running, LEDR[1] paused, LEDR[9:2] alarm.
REQ-008 SHALL have ports HEX0..HEX3  output  7 each  active-low 7-segment digits: seconds units, seconds tens, minutes units, minutes tens.

Function
REQ-009 SHALL pass each KEY bit through a 2-flop synchronizer; a press is a synchronized 1->0 transition, one-cycle pulse; action at 3rd rising edge after the pin falls.
REQ-010 SHALL hold preset registers pmin, psec (6 bits, 0..59) and time registers min, sec (6 bits, 0..59).
REQ-011 SHALL implement states IDLE, RUNNING, PAUSED, EXPIRED.
REQ-012 KEY[2]/KEY[3] press in IDLE or EXPIRED: load SW[5:0], clamped to 59, into pmin/psec and into min/sec; EXPIRED -> IDLE; ignored in RUNNING/PAUSED.
REQ-013 KEY[0] press: IDLE -> RUNNING if min:sec != 00:00, else ignored; RUNNING -> PAUSED; PAUSED -> RUNNING; ignored in EXPIRED.
REQ-014 KEY[1] press in any state: min/sec <= pmin/psec, state -> IDLE, prescaler cleared.
REQ-015 Prescaler counts 0..TICK_DIV-1 only in RUNNING, holds in PAUSED, clears in IDLE/EXPIRED; tick pulse when it equals TICK_DIV-1 in RUNNING.
REQ-016 On tick: sec>0 -> sec-1; sec=0 and min>0 -> min-1, sec=59; if result is 00:00, state -> EXPIRED same edge.
REQ-017 Same-cycle tick and KEY[0] press in RUNNING: decrement applies and state -> PAUSED (or EXPIRED if result 00:00, pause ignored).
REQ-018 Same-cycle presses, priority: KEY[1] > KEY[2] > KEY[3] > KEY[0]; lower-priority presses dropped.
REQ-019 HEX3/HEX2 = min/10, min%10; HEX1/HEX0 = sec/10, sec%10; registered, one cycle after time registers.
REQ-020 Digit encoding: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-021 LEDR[0]=1 iff RUNNING, LEDR[1]=1 iff PAUSED, registered; LEDR[9:2] per REQ-026.

Reset
REQ-022 reset high at a rising edge: state IDLE, pmin=psec=min=sec=0, prescaler 0, blink counter 0, synchronizer flops 1.
REQ-023 Outputs after reset: HEX0..HEX3 = 1000000, LEDR = 0.
REQ-024 reset mid-count or in EXPIRED: same as REQ-022; no tick, load or alarm in that cycle.

Configuration
REQ-025 Macro ALARM_BLINK_EN SHALL select the alarm display.
REQ-026 Defined: in EXPIRED, LEDR[9:2] all toggle every BLINK_DIV cycles starting at 11111111 on entry; undefined: LEDR[9:2] = 11111111 steady in EXPIRED; both: 0 in other states.

Verification
REQ-027 TICK_DIV=10: SW=2, KEY[3] press, KEY[0] press -> HEX0 shows 2,1,0 at 10-cycle spacing; EXPIRED at 00:00; LEDR[0]=0.
REQ-028 TICK_DIV=10: preset 01:00, start -> after first tick HEX shows 00:59 (HEX3..HEX0 = 0,0,5,9).
REQ-029 Start at 00:05, pause after 12 cycles, hold 50 cycles, resume -> no decrement while paused; next tick 8 cycles after resume.
REQ-030 SW=63, KEY[2] press -> pmin=59, HEX3/HEX2 show 5,9; KEY[0] with 00:00 preset -> stays IDLE.
REQ-031 Running at 00:03, KEY[1] press -> IDLE, time = preset; reset mid-run -> HEX all 1000000, LEDR=0.
REQ-032 ALARM_BLINK_EN defined, BLINK_DIV=4, expire -> LEDR[9:2] toggles every 4 cycles; undefined -> steady 11111111.
